blood_counter: RTL and testbench

Health ("blood") tracker for a two-player fighting game. It holds one 8-bit health value per player, packed into a 16-bit word. On each refresh strobe it subtracts per-player damage, saturating at zero, and raises a sticky game-over flag when either player reaches zero. It sits between the hit/damage logic (source of blood_dec) and the HUD/game-state controller (consumers of blood and over).

---
 rtl/blood_pkg.sv | 7 +
 rtl/blood_lane.sv | 35 +++
 rtl/blood_counter.sv | 60 ++++++
 tb/tb_blood_counter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/blood_pkg.sv
// Shared constants and types for the two-player health tracker.
package blood_pkg;
    localparam int unsigned HP_W = 8;
    localparam logic [HP_W-1:0] INIT_HP = 8'd100;

    typedef logic [HP_W-1:0] hp_t;
endpackage

// File: rtl/blood_lane.sv
// One player's health register with saturating damage subtraction.
module blood_lane
    import blood_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  hp_t  dec,
    output hp_t  hp,
    output logic zero_next
);

    hp_t r_hp;
    hp_t w_next;

    // Damage at or above current health clamps to zero instead of wrapping.
    always_comb begin
        w_next = '0;
        if (dec < r_hp) begin
            w_next = r_hp - dec;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hp <= INIT_HP;
        end else if (en) begin
            r_hp <= w_next;
        end
    end

    assign hp        = r_hp;
    assign zero_next = (w_next == '0);

endmodule

// File: rtl/blood_counter.sv
// Two-player health tracker: one damage update per rising edge of fresh, sticky game-over.
module blood_counter
    import blood_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              keep,
    input  logic              fresh,
    input  logic [2*HP_W-1:0] blood_dec,
    output logic [2*HP_W-1:0] blood,
    output logic              over
);

    logic r_fresh_q;
    logic r_over;
    logic w_upd;
    logic w_en;
    hp_t  w_hp1;
    hp_t  w_hp2;
    logic w_zero1;
    logic w_zero2;

    assign w_upd = fresh & ~r_fresh_q;
    assign w_en  = w_upd & ~keep & ~r_over;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fresh_q <= 1'b0;
            r_over    <= 1'b0;
        end else begin
            r_fresh_q <= fresh;
            // zero_next reflects the post-update value, so over rises on the same edge.
            if (w_en && (w_zero1 || w_zero2)) begin
                r_over <= 1'b1;
            end
        end
    end

    blood_lane u_lane_p1 (
        .clk       (clk),
        .reset     (reset),
        .en        (w_en),
        .dec       (blood_dec[2*HP_W-1:HP_W]),
        .hp        (w_hp1),
        .zero_next (w_zero1)
    );

    blood_lane u_lane_p2 (
        .clk       (clk),
        .reset     (reset),
        .en        (w_en),
        .dec       (blood_dec[HP_W-1:0]),
        .hp        (w_hp2),
        .zero_next (w_zero2)
    );

    assign blood = {w_hp1, w_hp2};
    assign over  = r_over;

endmodule

// File: tb/tb_blood_counter.sv
// Directed vector bench for blood_counter: one table row per clock cycle.
module tb_blood_counter;

    typedef struct {
        logic        rst_n;
        logic        keep;
        logic        fresh;
        logic [15:0] dec;
        logic [15:0] exp_blood;
        logic        exp_over;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        keep = 1'b0;
    logic        fresh = 1'b0;
    logic [15:0] blood_dec = '0;
    logic [15:0] blood;
    logic        over;

    int unsigned checks = 0;
    int unsigned failures = 0;
    vec_t        vecs[$];

    blood_counter dut (
        .clk       (clk),
        .reset     (reset),
        .keep      (keep),
        .fresh     (fresh),
        .blood_dec (blood_dec),
        .blood     (blood),
        .over      (over)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic k, input logic f, input logic [15:0] d,
                       input logic [15:0] eb, input logic eo, input string n);
        vec_t v;
        v.rst_n = r; v.keep = k; v.fresh = f; v.dec = d;
        v.exp_blood = eb; v.exp_over = eo; v.name = n;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] hp;

        // Reset held low with fresh toggling: nothing may move.
        for (int i = 0; i < 10; i++)
            add(1'b0, 1'b0, (i % 2) == 0, 16'h0A0A, 16'h6464, 1'b0, "reset_hold");

        // Freeze: every fresh edge under keep is discarded.
        for (int i = 0; i < 20; i++)
            add(1'b1, 1'b1, (i % 2) == 0, 16'h0A0A, 16'h6464, 1'b0, "freeze");

        // Countdown by 10 per pulse; over rises with the pulse that reaches zero.
        hp = 8'd100;
        for (int k = 1; k <= 10; k++) begin
            hp = hp - 8'd10;
            add(1'b1, 1'b0, 1'b1, 16'h0A0A, {hp, hp}, hp == 8'd0, "countdown_rise");
            add(1'b1, 1'b0, 1'b0, 16'h0A0A, {hp, hp}, hp == 8'd0, "countdown_low");
        end
        for (int k = 0; k < 2; k++) begin
            add(1'b1, 1'b0, 1'b1, 16'h0A0A, 16'h0000, 1'b1, "after_over_rise");
            add(1'b1, 1'b0, 1'b0, 16'h0A0A, 16'h0000, 1'b1, "after_over_low");
        end

        // Mid-game reset with fresh high during reset, then countdown resumes.
        add(1'b0, 1'b0, 1'b1, 16'h0A0A, 16'h6464, 1'b0, "reset_midgame");
        add(1'b1, 1'b0, 1'b0, 16'h0A0A, 16'h6464, 1'b0, "post_reset_idle");
        add(1'b1, 1'b0, 1'b1, 16'h0A0A, 16'h5A5A, 1'b0, "resume");
        add(1'b1, 1'b0, 1'b0, 16'h0A0A, 16'h5A5A, 1'b0, "resume_low");

        // Saturation on player 1, partial damage on player 2.
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h6464, 1'b0, "reset_sat");
        add(1'b1, 1'b0, 1'b1, 16'h7003, 16'h0061, 1'b1, "saturate");
        add(1'b1, 1'b0, 1'b0, 16'h7003, 16'h0061, 1'b1, "saturate_low");
        add(1'b1, 1'b0, 1'b1, 16'h7003, 16'h0061, 1'b1, "frozen_by_over");
        add(1'b1, 1'b1, 1'b0, 16'h7003, 16'h0061, 1'b1, "keep_no_clear");

        // Fresh held high for 8 cycles: exactly one update.
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h6464, 1'b0, "reset_edge");
        for (int i = 0; i < 8; i++)
            add(1'b1, 1'b0, 1'b1, 16'h0102, 16'h6362, 1'b0, "fresh_held");
        add(1'b1, 1'b0, 1'b0, 16'h0102, 16'h6362, 1'b0, "fresh_release");

        // An edge during keep is lost, not deferred to when keep drops.
        add(1'b1, 1'b1, 1'b1, 16'h0102, 16'h6362, 1'b0, "keep_edge");
        add(1'b1, 1'b0, 1'b1, 16'h0102, 16'h6362, 1'b0, "keep_edge_lost");
        add(1'b1, 1'b0, 1'b0, 16'h0000, 16'h6362, 1'b0, "idle");
        add(1'b1, 1'b0, 1'b1, 16'h0000, 16'h6362, 1'b0, "zero_damage");
        add(1'b1, 1'b0, 1'b0, 16'h6301, 16'h6362, 1'b0, "idle2");
        add(1'b1, 1'b0, 1'b1, 16'h6301, 16'h0061, 1'b1, "exact_zero");

        foreach (vecs[i]) begin
            @(negedge clk);
            reset     = vecs[i].rst_n;
            keep      = vecs[i].keep;
            fresh     = vecs[i].fresh;
            blood_dec = vecs[i].dec;
            @(posedge clk);
            #1;
            checks++;
            if (blood !== vecs[i].exp_blood) begin
                failures++;
                $display("FAIL row%0d %s blood: got=%h exp=%h", i, vecs[i].name, blood, vecs[i].exp_blood);
            end
            checks++;
            if (over !== vecs[i].exp_over) begin
                failures++;
                $display("FAIL row%0d %s over: got=%b exp=%b", i, vecs[i].name, over, vecs[i].exp_over);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
